// File: rtl/sra_32_structural_if.sv
// Operand/result bundle for the 32-bit arithmetic right shifter.
// SRA_LOGICAL_EN adds the logical (zero-fill) select line.
interface sra_32_structural_if;
    logic [31:0] a;
    logic [4:0]  b;
    logic [31:0] s;
    logic [31:0] s_q;
`ifdef SRA_LOGICAL_EN
    logic        logical;

    modport master (output a, output b, output logical, input s, input s_q);
    modport slave  (input a, input b, input logical, output s, output s_q);
`else
    modport master (output a, output b, input s, input s_q);
    modport slave  (input a, input b, output s, output s_q);
`endif
endinterface

// File: rtl/sra_32_structural.sv
// Structural 5-stage logarithmic barrel shifter (SRA) with a registered result.
// Optional SRA_LOGICAL_EN selects zero fill so the same block also serves SRL.

// Gate-level 2:1 mux: y = sel ? d1 : d0
module sra_mux2_cell (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);
    logic sel_n;
    logic term0;
    logic term1;

    assign sel_n = ~sel;
    assign term0 = d0 & sel_n;
    assign term1 = d1 & sel;
    assign y     = term0 | term1;
endmodule

module sra_32_structural (
    input  logic                  clk,
    input  logic                  rst,
    sra_32_structural_if.slave    bus
);
    localparam int WIDTH  = 32;
    localparam int STAGES = 5;

    // stage_data[0] is the operand; stage_data[k+1] is the output of stage k
    logic [WIDTH-1:0] stage_data [STAGES+1];
    logic             fill;
    logic [WIDTH-1:0] s_comb;
    logic [WIDTH-1:0] s_q_reg;
    logic [WIDTH-1:0] s_q_next;

    // Fill always comes from the original operand, never from an intermediate stage
`ifdef SRA_LOGICAL_EN
    logic logical_n;
    assign logical_n = ~bus.logical;
    assign fill      = bus.a[WIDTH-1] & logical_n;
`else
    assign fill      = bus.a[WIDTH-1];
`endif

    assign stage_data[0] = bus.a;

    genvar gk;
    genvar gi;
    generate
        for (gk = 0; gk < STAGES; gk++) begin : g_stage
            localparam int SHIFT = 1 << gk;
            for (gi = 0; gi < WIDTH; gi++) begin : g_bit
                if (gi + SHIFT <= WIDTH - 1) begin : g_pass
                    sra_mux2_cell u_mux (
                        .d0  (stage_data[gk][gi]),
                        .d1  (stage_data[gk][gi+SHIFT]),
                        .sel (bus.b[gk]),
                        .y   (stage_data[gk+1][gi])
                    );
                end else begin : g_fill
                    sra_mux2_cell u_mux (
                        .d0  (stage_data[gk][gi]),
                        .d1  (fill),
                        .sel (bus.b[gk]),
                        .y   (stage_data[gk+1][gi])
                    );
                end
            end
        end
    endgenerate

    assign s_comb   = stage_data[STAGES];
    assign s_q_next = s_comb;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q_reg <= '0;
        end else begin
            s_q_reg <= s_q_next;
        end
    end

    assign bus.s   = s_comb;
    assign bus.s_q = s_q_reg;
endmodule

// File: tb/tb_sra_32_structural.sv
// Self-checking bench for sra_32_structural: directed vectors, random sweep
// against a floor-division reference model, and the registered output path.
module tb_sra_32_structural;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    sra_32_structural_if bus ();

    sra_32_structural dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic shift right by b is floor(a / 2^b); logical is unsigned division
    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] b,
                                              input logic lg);
        longint sa;
        longint d;
        longint q;
        d = longint'(1) << b;
        if (lg) begin
            sa = longint'({32'h0, a});
            q  = sa / d;
        end else begin
            sa = longint'($signed(a));
            q  = sa / d;
            if (sa < 0 && (sa % d) != 0) q = q - 1;
        end
        return q[31:0];
    endfunction

    task automatic set_in(input logic [31:0] a, input logic [4:0] b, input logic lg);
        bus.a = a;
        bus.b = b;
`ifdef SRA_LOGICAL_EN
        bus.logical = lg;
`else
        if (lg) $display("note: logical select requested without SRA_LOGICAL_EN");
`endif
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        set_in($urandom, 5'($urandom_range(0, 31)), 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (bus.s_q !== 32'h0) begin
            failures++;
            $display("FAIL reset_s_q actual=%h required=%h", bus.s_q, 32'h0);
        end else $display("reset_s_q ok s_q=%h", bus.s_q);
    endtask

    task automatic test_directed();
        logic [31:0] va [10];
        logic [4:0]  vb [10];
        logic [31:0] vs [10];
        va = '{32'h00000000, 32'h04040404, 32'h08080808, 32'h12345678, 32'hFFFFFFF6,
               32'hC0000000, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001};
        vb = '{5'd0, 5'd1, 5'd2, 5'd0, 5'd1, 5'd4, 5'd31, 5'd31, 5'd17, 5'd0};
        vs = '{32'h00000000, 32'h02020202, 32'h02020202, 32'h12345678, 32'hFFFFFFFB,
               32'hFC000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h80000001};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_in(va[i], vb[i], 1'b0);
            #1;
            checks++;
            if (bus.s !== vs[i]) begin
                failures++;
                $display("FAIL directed_%0d a=%h b=%0d actual=%h required=%h",
                         i, va[i], vb[i], bus.s, vs[i]);
            end else $display("directed_%0d a=%h b=%0d s=%h ok", i, va[i], vb[i], bus.s);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] a;
        logic [31:0] exp_s;
        for (int rep = 0; rep < 4; rep++) begin
            for (int sh = 0; sh < 32; sh++) begin
                a = $urandom;
                if (rep == 0) a[31] = 1'b1;
                if (rep == 1) a[31] = 1'b0;
                @(negedge clk);
                set_in(a, 5'(sh), 1'b0);
                #1;
                exp_s = ref_shift(a, 5'(sh), 1'b0);
                checks++;
                if (bus.s !== exp_s) begin
                    failures++;
                    $display("FAIL sweep a=%h b=%0d actual=%h required=%h", a, sh, bus.s, exp_s);
                end else $display("sweep a=%h b=%0d s=%h ok", a, sh, bus.s);
            end
        end
    endtask

    task automatic test_register();
        @(negedge clk);
        rst = 1'b0;
        set_in(32'hC0000000, 5'd4, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (bus.s_q !== 32'hFC000000) begin
            failures++;
            $display("FAIL reg_follow actual=%h required=%h", bus.s_q, 32'hFC000000);
        end else $display("reg_follow s_q=%h ok", bus.s_q);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.s_q !== 32'h0) begin
            failures++;
            $display("FAIL reg_midreset actual=%h required=%h", bus.s_q, 32'h0);
        end else $display("reg_midreset s_q=%h ok", bus.s_q);
        checks++;
        if (bus.s !== 32'hFC000000) begin
            failures++;
            $display("FAIL comb_during_reset actual=%h required=%h", bus.s, 32'hFC000000);
        end else $display("comb_during_reset s=%h ok", bus.s);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.s_q !== 32'hFC000000) begin
            failures++;
            $display("FAIL reg_resume actual=%h required=%h", bus.s_q, 32'hFC000000);
        end else $display("reg_resume s_q=%h ok", bus.s_q);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [4:0]  b;
        logic [31:0] exp_q;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = 5'($urandom_range(0, 31));
            @(negedge clk);
            set_in(a, b, 1'b0);
            exp_q = ref_shift(a, b, 1'b0);
            @(posedge clk);
            #1;
            checks++;
            if (bus.s_q !== exp_q) begin
                failures++;
                $display("FAIL b2b_s_q a=%h b=%0d actual=%h required=%h", a, b, bus.s_q, exp_q);
            end else $display("b2b a=%h b=%0d s_q=%h ok", a, b, bus.s_q);
        end
    endtask

`ifdef SRA_LOGICAL_EN
    task automatic test_logical();
        logic [31:0] a;
        logic [4:0]  b;
        logic        lg;
        logic [31:0] exp_s;
        @(negedge clk);
        set_in(32'hC0000000, 5'd4, 1'b1);
        #1;
        checks++;
        if (bus.s !== 32'h0C000000) begin
            failures++;
            $display("FAIL logical_srl actual=%h required=%h", bus.s, 32'h0C000000);
        end else $display("logical_srl s=%h ok", bus.s);
        @(negedge clk);
        set_in(32'hC0000000, 5'd4, 1'b0);
        #1;
        checks++;
        if (bus.s !== 32'hFC000000) begin
            failures++;
            $display("FAIL logical_sra actual=%h required=%h", bus.s, 32'hFC000000);
        end else $display("logical_sra s=%h ok", bus.s);
        for (int i = 0; i < 40; i++) begin
            a  = $urandom;
            b  = 5'($urandom_range(0, 31));
            lg = 1'($urandom_range(0, 1));
            @(negedge clk);
            set_in(a, b, lg);
            #1;
            exp_s = ref_shift(a, b, lg);
            checks++;
            if (bus.s !== exp_s) begin
                failures++;
                $display("FAIL logical_rand a=%h b=%0d lg=%0d actual=%h required=%h",
                         a, b, lg, bus.s, exp_s);
            end else $display("logical_rand a=%h b=%0d lg=%0d s=%h ok", a, b, lg, bus.s);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        set_in(32'h0, 5'd0, 1'b0);
        test_reset();
        test_directed();
        test_sweep();
        test_register();
        test_back_to_back();
`ifdef SRA_LOGICAL_EN
        test_logical();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
